jk_exciter: RTL and testbench



---
 rtl/jk_pkg.sv | 26 ++
 rtl/jk_excite_bit.sv | 39 +++
 rtl/jk_exciter.sv | 129 ++++++++++++
 tb/tb_jk_exciter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jk_pkg
//  Purpose : Shared definitions for the JK exciter: FSM state encoding and
//            the two-bit {J,K} drive codes applied to each flip-flop.
//  Ports   : none (package)
//  Options : none here; see jk_excite_bit for JK_EXCITER_TOGGLE_EN
//  Revision: 1.0 - initial release
// ============================================================================
package jk_pkg;

  // Sequencer states: accept a target, drive the bank, check the result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // {J,K} drive codes.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_excite_bit.sv
`default_nettype none
// ============================================================================
//  Module  : jk_excite_bit
//  Purpose : Combinational JK excitation for one flip-flop. Given the
//            current Q (cur) and the wanted next Q (nxt), produce {j,k}.
//  Ports   : cur - current Q of the flop (tracked model)
//            nxt - requested next Q
//            j,k - excitation outputs
//  Options : JK_EXCITER_TOGGLE_EN - changed bits use toggle (11) instead of
//            set (10) / reset (01). Unchanged bits always hold (00).
//  Revision: 1.0 - initial release
// ============================================================================
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic cur,
  input  logic nxt,
  output logic j,
  output logic k
);

  logic [1:0] w_code;

  always_comb begin
    w_code = JK_HOLD;
    if (cur != nxt) begin
`ifdef JK_EXCITER_TOGGLE_EN
      w_code = JK_TGL;
`else
      w_code = nxt ? JK_SET : JK_RST;
`endif
    end
  end

  assign j = w_code[1];
  assign k = w_code[0];

endmodule : jk_excite_bit
`default_nettype wire

// File: rtl/jk_exciter.sv
`default_nettype none
// ============================================================================
//  Module  : jk_exciter
//  Purpose : Drives the J/K inputs of a WIDTH-bit JK flip-flop bank so the
//            bank reaches a requested target word, then checks the fed-back
//            Q against the target. A tracked model of the bank's Q feeds the
//            excitation; it is resynchronised to the real Q after each check.
//  Ports   : clk       - rising-edge clock
//            reset     - synchronous active-high reset (shared with the bank)
//            tgt_valid - target word offered
//            tgt_ready - target can be accepted (IDLE only)
//            tgt_data  - requested next Q of the bank
//            j, k      - registered J/K drive, one bit per flop
//            q_fb      - Q fed back from the bank
//            done      - one-cycle pulse when an update attempt completes
//            mismatch  - valid with done; q_fb differed from the target
//            err_cnt   - saturating mismatch count since reset
//  Options : JK_EXCITER_TOGGLE_EN - toggle encoding for changed bits
//  Revision: 1.0 - initial release
// ============================================================================
module jk_exciter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_model;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_accept;
  logic             w_mismatch;

  // Excitation is computed from the model against the offered word so the
  // registered j/k are ready the cycle after accept.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_excite_bit u_bit (
      .cur (r_model[gi]),
      .nxt (tgt_data[gi]),
      .j   (w_j[gi]),
      .k   (w_k[gi])
    );
  end

  assign tgt_ready  = (r_state == ST_IDLE);
  assign w_accept   = tgt_valid && tgt_ready;
  assign w_mismatch = (q_fb != r_tgt);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_DRIVE;
      ST_DRIVE: w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt      <= '0;
      r_model    <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt <= tgt_data;
            r_j   <= w_j;
            r_k   <= w_k;
          end
        end
        ST_DRIVE: begin
          // The bank latches j/k on this edge; release the drive afterwards.
          r_j <= '0;
          r_k <= '0;
        end
        ST_CHECK: begin
          r_done     <= 1'b1;
          r_mismatch <= w_mismatch;
          r_model    <= q_fb;
          if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign j        = r_j;
  assign k        = r_k;
  assign done     = r_done;
  assign mismatch = r_mismatch;
  assign err_cnt  = r_err_cnt;

endmodule : jk_exciter
`default_nettype wire

// File: tb/tb_jk_exciter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jk_exciter
//  Purpose : Self-checking bench for jk_exciter driving a 4-bit JK flop bank
//            on the same clk/reset; q_fb is the bank Q with an optional
//            stuck-at-1 mask to create mismatches.
//  Options : JK_EXCITER_TOGGLE_EN - selects toggle-encoding expectations
//  Revision: 1.0 - initial release
// ============================================================================
module tb_jk_exciter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt_data;
  logic [3:0] j, k;
  logic [3:0] q_fb;
  logic       done;
  logic       mismatch;
  logic [7:0] err_cnt;

  logic [3:0] q_bank;
  logic [3:0] stuck;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jk_exciter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .done      (done),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  // Behavioural JK flip-flop bank.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) q_bank[i] <= 1'b0;
      else case ({j[i], k[i]})
        2'b01:   q_bank[i] <= 1'b0;
        2'b10:   q_bank[i] <= 1'b1;
        2'b11:   q_bank[i] <= ~q_bank[i];
        default: q_bank[i] <= q_bank[i];
      endcase
    end
  end

  assign q_fb = q_bank | stuck;

  // Present a target and advance through the accept edge.
  task automatic offer(input logic [3:0] t);
    tgt_valid = 1'b1;
    tgt_data  = t;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; tgt_valid = 1'b0; tgt_data = 4'h0; stuck = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if ({tgt_ready, j, k, done, mismatch, err_cnt, q_bank} !== {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h0, 4'h0}) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b j=%b k=%b done=%b mm=%b cnt=%0d q=%b, expected 1 0000 0000 0 0 0 0000",
               tgt_ready, j, k, done, mismatch, err_cnt, q_bank);
    end
  endtask

  task automatic test_first_target;
    logic [3:0] ej, ek;
`ifdef JK_EXCITER_TOGGLE_EN
    ej = 4'b1010; ek = 4'b1010;
`else
    ej = 4'b1010; ek = 4'b0000;
`endif
    offer(4'b1010);
    n_checks++;
    if ({tgt_ready, j, k} !== {1'b0, ej, ek}) begin
      n_errors++;
      $display("FAIL first_drive: ready=%b j=%b k=%b, expected ready=0 j=%b k=%b", tgt_ready, j, k, ej, ek);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({j, k, done, q_bank} !== {4'h0, 4'h0, 1'b0, 4'b1010}) begin
      n_errors++;
      $display("FAIL first_check_cycle: j=%b k=%b done=%b q=%b, expected 0000 0000 0 1010", j, k, done, q_bank);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, tgt_ready, err_cnt} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
      n_errors++;
      $display("FAIL first_done: done=%b mm=%b ready=%b cnt=%0d, expected 1 0 1 0", done, mismatch, tgt_ready, err_cnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL first_done_pulse: done=%b, expected 0", done);
    end
  endtask

  task automatic test_change_target;
    logic [3:0] ej, ek;
`ifdef JK_EXCITER_TOGGLE_EN
    ej = 4'b1100; ek = 4'b1100;
`else
    ej = 4'b0100; ek = 4'b1000;
`endif
    offer(4'b0110);
    n_checks++;
    if ({j, k} !== {ej, ek}) begin
      n_errors++;
      $display("FAIL change_drive: j=%b k=%b, expected j=%b k=%b", j, k, ej, ek);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, q_bank} !== {1'b1, 1'b0, 4'b0110}) begin
      n_errors++;
      $display("FAIL change_done: done=%b mm=%b q=%b, expected 1 0 0110", done, mismatch, q_bank);
    end
  endtask

  // Same target again with tgt_valid held through DRIVE/CHECK.
  task automatic test_hold_same;
    tgt_valid = 1'b1; tgt_data = 4'b0110;
    @(posedge clk); #1;
    n_checks++;
    if ({tgt_ready, j, k} !== {1'b0, 4'h0, 4'h0}) begin
      n_errors++;
      $display("FAIL same_drive: ready=%b j=%b k=%b, expected 0 0000 0000", tgt_ready, j, k);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({tgt_ready, done} !== {1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL same_check_cycle: ready=%b done=%b, expected 0 0", tgt_ready, done);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, err_cnt, q_bank} !== {1'b1, 1'b0, 8'd0, 4'b0110}) begin
      n_errors++;
      $display("FAIL same_done: done=%b mm=%b cnt=%0d q=%b, expected 1 0 0 0110", done, mismatch, err_cnt, q_bank);
    end
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done, tgt_ready} !== {1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL single_accept: done=%b ready=%b, expected 0 1", done, tgt_ready);
    end
  endtask

  // Second target accepted in the cycle done is high.
  task automatic test_back_to_back;
    logic [3:0] ej, ek;
    offer(4'b1010);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({done, q_bank} !== {1'b1, 4'b1010}) begin
      n_errors++;
      $display("FAIL b2b_first_done: done=%b q=%b, expected 1 1010", done, q_bank);
    end
`ifdef JK_EXCITER_TOGGLE_EN
    ej = 4'b1100; ek = 4'b1100;
`else
    ej = 4'b0100; ek = 4'b1000;
`endif
    offer(4'b0110);
    n_checks++;
    if ({tgt_ready, done, j, k} !== {1'b0, 1'b0, ej, ek}) begin
      n_errors++;
      $display("FAIL b2b_second_drive: ready=%b done=%b j=%b k=%b, expected 0 0 %b %b",
               tgt_ready, done, j, k, ej, ek);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, q_bank} !== {1'b1, 1'b0, 4'b0110}) begin
      n_errors++;
      $display("FAIL b2b_second_done: done=%b mm=%b q=%b, expected 1 0 0110", done, mismatch, q_bank);
    end
  endtask

  task automatic test_mismatch;
    logic [3:0] ej, ek;
    stuck = 4'b0001;
`ifdef JK_EXCITER_TOGGLE_EN
    ej = 4'b0110; ek = 4'b0110;
`else
    ej = 4'b0000; ek = 4'b0110;
`endif
    offer(4'b0000);
    n_checks++;
    if ({j, k} !== {ej, ek}) begin
      n_errors++;
      $display("FAIL mm_drive: j=%b k=%b, expected %b %b", j, k, ej, ek);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      n_errors++;
      $display("FAIL mm_done: done=%b mm=%b cnt=%0d, expected 1 1 1", done, mismatch, err_cnt);
    end
    // Model resynced to 0001, so this target needs no drive.
    offer(4'b0001);
    n_checks++;
    if ({j, k} !== {4'h0, 4'h0}) begin
      n_errors++;
      $display("FAIL resync_drive: j=%b k=%b, expected 0000 0000", j, k);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({done, mismatch, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      n_errors++;
      $display("FAIL resync_done: done=%b mm=%b cnt=%0d, expected 1 0 1", done, mismatch, err_cnt);
    end
    stuck = 4'b0000;
  endtask

  task automatic test_reset_in_drive;
    offer(4'b1111);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({j, k, tgt_ready, done, mismatch, err_cnt, q_bank} !== {4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 4'h0}) begin
      n_errors++;
      $display("FAIL reset_drive: j=%b k=%b ready=%b done=%b mm=%b cnt=%0d q=%b, expected 0000 0000 1 0 0 0 0000",
               j, k, tgt_ready, done, mismatch, err_cnt, q_bank);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({done, tgt_ready} !== {1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL reset_no_done[%0d]: done=%b ready=%b, expected 0 1", c, done, tgt_ready);
      end
    end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    stuck = 4'b0001;
    for (int i = 0; i < 260; i++) begin
      offer(4'b0000);
      repeat (2) @(posedge clk); #1;
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if ({done, mismatch, err_cnt} !== {1'b1, 1'b1, 8'(exp_cnt)}) begin
        n_errors++;
        $display("FAIL sat_iter[%0d]: done=%b mm=%b cnt=%0d, expected 1 1 %0d", i, done, mismatch, err_cnt, exp_cnt);
      end
    end
    stuck = 4'b0000;
    @(posedge clk); #1;
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_hold: cnt=%0d, expected 255", err_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_first_target;
    test_change_target;
    test_hold_same;
    test_back_to_back;
    test_mismatch;
    test_reset_in_drive;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_jk_exciter
`default_nettype wire
